// File: rtl/udp_echo_pkg.sv
// Shared types and constants for the UDP echo responder.
package udp_echo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_STORE,
    ST_DROP,
    ST_TX_HDR,
    ST_TX_DATA
  } echo_state_t;

  localparam int unsigned UDP_HEADER_BYTES = 8;

endpackage

// File: rtl/udp_echo_buffer.sv
// Simple dual-port byte RAM holding one datagram payload.
// Synchronous write, registered read that holds its value while rd_en is low.
module udp_echo_buffer #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_echo_responder.sv
// Store-and-forward UDP echo endpoint: buffers one datagram for LISTEN_PORT and
// sends it back with addresses/ports swapped. Counters built with UDP_ECHO_STATS_EN.
module udp_echo_responder
  import udp_echo_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 2048,
  parameter logic [15:0] LISTEN_PORT = 16'd7,
  parameter logic [7:0]  IP_TTL      = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        udp_rx_hdr_valid,
  output logic        udp_rx_hdr_ready,
  input  logic [31:0] udp_rx_ip_source_ip,
  input  logic [31:0] udp_rx_ip_dest_ip,
  input  logic [15:0] udp_rx_source_port,
  input  logic [15:0] udp_rx_dest_port,
  input  logic [15:0] udp_rx_length,
  input  logic [7:0]  udp_rx_payload_tdata,
  input  logic        udp_rx_payload_tvalid,
  output logic        udp_rx_payload_tready,
  input  logic        udp_rx_payload_tlast,
  input  logic        udp_rx_payload_tuser,
  output logic        udp_tx_hdr_valid,
  input  logic        udp_tx_hdr_ready,
  output logic [5:0]  udp_tx_ip_dscp,
  output logic [1:0]  udp_tx_ip_ecn,
  output logic [7:0]  udp_tx_ip_ttl,
  output logic [31:0] udp_tx_ip_source_ip,
  output logic [31:0] udp_tx_ip_dest_ip,
  output logic [15:0] udp_tx_source_port,
  output logic [15:0] udp_tx_dest_port,
  output logic [15:0] udp_tx_length,
  output logic [15:0] udp_tx_checksum,
  output logic [7:0]  udp_tx_payload_tdata,
  output logic        udp_tx_payload_tvalid,
  input  logic        udp_tx_payload_tready,
  output logic        udp_tx_payload_tlast,
  output logic        udp_tx_payload_tuser,
  output logic        busy,
  output logic [31:0] echo_count,
  output logic [31:0] drop_count
);

  localparam int unsigned AW = $clog2(MAX_PAYLOAD);
  localparam int unsigned CW = AW + 1;
  localparam logic [16:0] MIN_LEN   = 17'(UDP_HEADER_BYTES + 1);
  localparam logic [16:0] MAX_LEN   = 17'(MAX_PAYLOAD + UDP_HEADER_BYTES);
  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_PAYLOAD - 1);

  echo_state_t state, state_nxt;

  logic [31:0]   lat_src_ip, lat_dst_ip;
  logic [15:0]   lat_src_port;
  logic [CW-1:0] count, rd_addr;
  logic          rx_hdr_hs, rx_beat, tx_hdr_hs, tx_beat, hdr_accept;
  logic          in_tx, out_free, s1_free, s1_valid, s1_last, rd_en;
  logic [7:0]    rd_data;

  assign rx_hdr_hs  = udp_rx_hdr_valid && udp_rx_hdr_ready;
  assign rx_beat    = udp_rx_payload_tvalid && udp_rx_payload_tready;
  assign tx_hdr_hs  = udp_tx_hdr_valid && udp_tx_hdr_ready;
  assign tx_beat    = udp_tx_payload_tvalid && udp_tx_payload_tready;
  assign hdr_accept = (udp_rx_dest_port == LISTEN_PORT) &&
                      ({1'b0, udp_rx_length} >= MIN_LEN) &&
                      ({1'b0, udp_rx_length} <= MAX_LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (rx_hdr_hs) state_nxt = hdr_accept ? ST_RX_STORE : ST_DROP;
      ST_RX_STORE:
        if (rx_beat) begin
          if (udp_rx_payload_tlast)
            state_nxt = udp_rx_payload_tuser ? ST_IDLE : ST_TX_HDR;
          else if (count == LAST_SLOT)
            state_nxt = ST_DROP;
        end
      ST_DROP:
        if (rx_beat && udp_rx_payload_tlast) state_nxt = ST_IDLE;
      ST_TX_HDR:
        if (tx_hdr_hs) state_nxt = ST_TX_DATA;
      ST_TX_DATA:
        if (tx_beat && udp_tx_payload_tlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    udp_rx_hdr_ready      = (state == ST_IDLE);
    udp_rx_payload_tready = (state == ST_RX_STORE) || (state == ST_DROP);
    udp_tx_hdr_valid      = (state == ST_TX_HDR);
    busy                  = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_src_ip   <= '0;
      lat_dst_ip   <= '0;
      lat_src_port <= '0;
      count        <= '0;
    end else if (state == ST_IDLE && rx_hdr_hs) begin
      lat_src_ip   <= udp_rx_ip_source_ip;
      lat_dst_ip   <= udp_rx_ip_dest_ip;
      lat_src_port <= udp_rx_source_port;
      count        <= '0;
    end else if (state == ST_RX_STORE && rx_beat) begin
      count <= count + CW'(1);
    end
  end

  assign udp_tx_ip_dscp      = '0;
  assign udp_tx_ip_ecn       = '0;
  assign udp_tx_ip_ttl       = IP_TTL;
  assign udp_tx_ip_source_ip = lat_dst_ip;
  assign udp_tx_ip_dest_ip   = lat_src_ip;
  assign udp_tx_source_port  = LISTEN_PORT;
  assign udp_tx_dest_port    = lat_src_port;
  assign udp_tx_length       = 16'(count) + 16'(UDP_HEADER_BYTES);
  assign udp_tx_checksum     = '0;
  assign udp_tx_payload_tuser = 1'b0;

  udp_echo_buffer #(
    .DEPTH (MAX_PAYLOAD)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (state == ST_RX_STORE && rx_beat),
    .wr_addr (count[AW-1:0]),
    .wr_data (udp_rx_payload_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr[AW-1:0]),
    .rd_data (rd_data)
  );

  // Two-stage read pipe (RAM register, output register) stalled as a unit by
  // tready, so the RAM output simply holds while the output stage is full.
  assign in_tx    = (state == ST_TX_DATA);
  assign out_free = !udp_tx_payload_tvalid || udp_tx_payload_tready;
  assign s1_free  = !s1_valid || out_free;
  assign rd_en    = in_tx && s1_free && (rd_addr != count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr               <= '0;
      s1_valid              <= 1'b0;
      s1_last               <= 1'b0;
      udp_tx_payload_tvalid <= 1'b0;
      udp_tx_payload_tlast  <= 1'b0;
      udp_tx_payload_tdata  <= '0;
    end else if (!in_tx) begin
      rd_addr               <= '0;
      s1_valid              <= 1'b0;
      s1_last               <= 1'b0;
      udp_tx_payload_tvalid <= 1'b0;
      udp_tx_payload_tlast  <= 1'b0;
    end else begin
      if (s1_free) begin
        s1_valid <= rd_en;
        s1_last  <= rd_en && (rd_addr == count - CW'(1));
      end
      if (rd_en) rd_addr <= rd_addr + CW'(1);
      if (out_free) begin
        udp_tx_payload_tvalid <= s1_valid;
        udp_tx_payload_tlast  <= s1_valid && s1_last;
        if (s1_valid) udp_tx_payload_tdata <= rd_data;
      end
    end
  end

`ifdef UDP_ECHO_STATS_EN
  logic echo_evt, drop_evt;

  assign echo_evt = in_tx && tx_beat && udp_tx_payload_tlast;
  assign drop_evt = rx_beat && udp_rx_payload_tlast &&
                    ((state == ST_DROP) ||
                     (state == ST_RX_STORE && udp_rx_payload_tuser));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_count <= '0;
      drop_count <= '0;
    end else begin
      if (echo_evt && echo_count != '1) echo_count <= echo_count + 32'd1;
      if (drop_evt && drop_count != '1) drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign echo_count = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_udp_echo_responder.sv
// Randomized self-checking bench for udp_echo_responder against a datagram-level model.
module tb_udp_echo_responder;

  localparam int unsigned MP   = 128;
  localparam logic [15:0] PORT = 16'd7;
  localparam logic [7:0]  TTL  = 8'd64;

  typedef struct packed {
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
    logic [15:0] csum;
  } hdr_t;

  logic        clk, reset;
  logic        udp_rx_hdr_valid, udp_rx_hdr_ready;
  logic [31:0] udp_rx_ip_source_ip, udp_rx_ip_dest_ip;
  logic [15:0] udp_rx_source_port, udp_rx_dest_port, udp_rx_length;
  logic [7:0]  udp_rx_payload_tdata;
  logic        udp_rx_payload_tvalid, udp_rx_payload_tready, udp_rx_payload_tlast, udp_rx_payload_tuser;
  logic        udp_tx_hdr_valid, udp_tx_hdr_ready;
  logic [5:0]  udp_tx_ip_dscp;
  logic [1:0]  udp_tx_ip_ecn;
  logic [7:0]  udp_tx_ip_ttl;
  logic [31:0] udp_tx_ip_source_ip, udp_tx_ip_dest_ip;
  logic [15:0] udp_tx_source_port, udp_tx_dest_port, udp_tx_length, udp_tx_checksum;
  logic [7:0]  udp_tx_payload_tdata;
  logic        udp_tx_payload_tvalid, udp_tx_payload_tready, udp_tx_payload_tlast, udp_tx_payload_tuser;
  logic        busy;
  logic [31:0] echo_count, drop_count;

  udp_echo_responder #(
    .MAX_PAYLOAD (MP),
    .LISTEN_PORT (PORT),
    .IP_TTL      (TTL)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .udp_rx_hdr_valid      (udp_rx_hdr_valid),
    .udp_rx_hdr_ready      (udp_rx_hdr_ready),
    .udp_rx_ip_source_ip   (udp_rx_ip_source_ip),
    .udp_rx_ip_dest_ip     (udp_rx_ip_dest_ip),
    .udp_rx_source_port    (udp_rx_source_port),
    .udp_rx_dest_port      (udp_rx_dest_port),
    .udp_rx_length         (udp_rx_length),
    .udp_rx_payload_tdata  (udp_rx_payload_tdata),
    .udp_rx_payload_tvalid (udp_rx_payload_tvalid),
    .udp_rx_payload_tready (udp_rx_payload_tready),
    .udp_rx_payload_tlast  (udp_rx_payload_tlast),
    .udp_rx_payload_tuser  (udp_rx_payload_tuser),
    .udp_tx_hdr_valid      (udp_tx_hdr_valid),
    .udp_tx_hdr_ready      (udp_tx_hdr_ready),
    .udp_tx_ip_dscp        (udp_tx_ip_dscp),
    .udp_tx_ip_ecn         (udp_tx_ip_ecn),
    .udp_tx_ip_ttl         (udp_tx_ip_ttl),
    .udp_tx_ip_source_ip   (udp_tx_ip_source_ip),
    .udp_tx_ip_dest_ip     (udp_tx_ip_dest_ip),
    .udp_tx_source_port    (udp_tx_source_port),
    .udp_tx_dest_port      (udp_tx_dest_port),
    .udp_tx_length         (udp_tx_length),
    .udp_tx_checksum       (udp_tx_checksum),
    .udp_tx_payload_tdata  (udp_tx_payload_tdata),
    .udp_tx_payload_tvalid (udp_tx_payload_tvalid),
    .udp_tx_payload_tready (udp_tx_payload_tready),
    .udp_tx_payload_tlast  (udp_tx_payload_tlast),
    .udp_tx_payload_tuser  (udp_tx_payload_tuser),
    .busy                  (busy),
    .echo_count            (echo_count),
    .drop_count            (drop_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  // Model state and capture queues
  logic [7:0]  pay_q[$];
  logic [9:0]  got_pay[$];
  hdr_t        got_hdr[$];
  bit          expect_echo;
  hdr_t        exp_hdr;
  int unsigned exp_n;
  longint unsigned echo_m, drop_m;
  int unsigned tx_mode, hdr_delay, hwait;
  bit          rx_gaps;

  initial begin
    udp_tx_payload_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      udp_tx_payload_tready = (tx_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    udp_tx_hdr_ready = 1'b0;
    hwait = 0;
    forever begin
      @(posedge clk); #1;
      if (udp_tx_hdr_valid) begin
        udp_tx_hdr_ready = (hwait >= hdr_delay);
        hwait++;
      end else begin
        udp_tx_hdr_ready = 1'b0;
        hwait = 0;
      end
    end
  end

  function automatic hdr_t cur_tx_hdr();
    hdr_t h;
    h = '{udp_tx_ip_dscp, udp_tx_ip_ecn, udp_tx_ip_ttl, udp_tx_ip_source_ip, udp_tx_ip_dest_ip,
          udp_tx_source_port, udp_tx_dest_port, udp_tx_length, udp_tx_checksum};
    return h;
  endfunction

  // Output monitor: captures handshakes, checks hold-while-stalled and latency rules
  bit          prev_hv, prev_hr, prev_tv, prev_tr, prev_tl, prev_beat_nl, last_pend;
  logic [7:0]  prev_td;
  hdr_t        prev_hdr;
  int unsigned hs_age;

  always @(negedge clk) begin
    if (reset) begin
      prev_hv = 0; prev_hr = 0; prev_tv = 0; prev_tr = 0; prev_tl = 0;
      prev_beat_nl = 0; last_pend = 0; hs_age = 0;
    end else begin
      if (last_pend) check_eq("hdr_valid_after_rx_tlast", udp_tx_hdr_valid, expect_echo);
      last_pend = udp_rx_payload_tvalid && udp_rx_payload_tready && udp_rx_payload_tlast;
      if (prev_hv && !prev_hr) begin
        check_eq("hdr_hold_valid", udp_tx_hdr_valid, 1'b1);
        check_eq("hdr_hold_fields", cur_tx_hdr(), prev_hdr);
      end
      if (prev_tv && !prev_tr)
        check_eq("tx_hold", {udp_tx_payload_tvalid, udp_tx_payload_tlast, udp_tx_payload_tdata},
                 {1'b1, prev_tl, prev_td});
      if (prev_beat_nl && tx_mode == 0) check_eq("tx_no_bubble", udp_tx_payload_tvalid, 1'b1);
      if (hs_age != 0) begin
        check_eq($sformatf("first_beat_latency_%0d", hs_age), udp_tx_payload_tvalid, hs_age == 3);
        hs_age = (hs_age == 3) ? 0 : hs_age + 1;
      end
      if (udp_tx_hdr_valid && udp_tx_hdr_ready) begin
        got_hdr.push_back(cur_tx_hdr());
        hs_age = 1;
      end
      if (udp_tx_payload_tvalid && udp_tx_payload_tready)
        got_pay.push_back({udp_tx_payload_tuser, udp_tx_payload_tlast, udp_tx_payload_tdata});
      prev_hv = udp_tx_hdr_valid;      prev_hr = udp_tx_hdr_ready;
      prev_tv = udp_tx_payload_tvalid; prev_tr = udp_tx_payload_tready;
      prev_tl = udp_tx_payload_tlast;  prev_td = udp_tx_payload_tdata;
      prev_hdr = cur_tx_hdr();
      prev_beat_nl = udp_tx_payload_tvalid && udp_tx_payload_tready && !udp_tx_payload_tlast;
    end
  end

  function automatic bit model_echoes(input logic [15:0] dp, input int unsigned hlen,
                                      input int unsigned n, input bit bad);
    if (dp != PORT) return 0;
    if (hlen < 9 || hlen > MP + 8) return 0;
    if (n > MP) return 0;
    return !bad;
  endfunction

  task automatic send_hdr(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                          input logic [15:0] dp, input logic [15:0] hlen);
    bit ok = 0;
    @(posedge clk); #1;
    udp_rx_ip_source_ip = sip; udp_rx_ip_dest_ip = dip;
    udp_rx_source_port = sp;   udp_rx_dest_port = dp;  udp_rx_length = hlen;
    udp_rx_hdr_valid = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      if (udp_rx_hdr_ready) ok = 1;
      @(posedge clk); #1;
      if (ok) break;
    end
    udp_rx_hdr_valid = 1'b0;
    if (!ok) check_eq("rx_hdr_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_payload(input bit bad);
    for (int i = 0; i < pay_q.size(); i++) begin
      bit ok = 0;
      if (rx_gaps && $urandom_range(0, 3) == 0) begin
        udp_rx_payload_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      udp_rx_payload_tdata  = pay_q[i];
      udp_rx_payload_tlast  = (i == pay_q.size() - 1);
      udp_rx_payload_tuser  = bad && (i == pay_q.size() - 1);
      udp_rx_payload_tvalid = 1'b1;
      for (int k = 0; k < 100; k++) begin
        if (udp_rx_payload_tready) ok = 1;
        @(posedge clk); #1;
        if (ok) break;
      end
      if (!ok) begin
        check_eq("rx_beat_timeout", 1'b0, 1'b1);
        break;
      end
    end
    udp_rx_payload_tvalid = 1'b0;
    udp_rx_payload_tlast  = 1'b0;
    udp_rx_payload_tuser  = 1'b0;
  endtask

  task automatic send_datagram(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                               input logic [15:0] dp, input int unsigned hlen, input int unsigned n,
                               input bit bad, input bit seq);
    pay_q.delete();
    for (int unsigned i = 0; i < n; i++) pay_q.push_back(seq ? 8'(i + 1) : 8'($urandom));
    expect_echo = model_echoes(dp, hlen, n, bad);
    exp_hdr = '{6'd0, 2'd0, TTL, dip, sip, PORT, sp, 16'(n + 8), 16'd0};
    exp_n = n;
    got_hdr.delete();
    got_pay.delete();
    send_hdr(sip, dip, sp, dp, 16'(hlen));
    send_payload(bad);
  endtask

  task automatic check_counters();
`ifdef UDP_ECHO_STATS_EN
    check_eq("echo_count", echo_count, 32'(echo_m));
    check_eq("drop_count", drop_count, 32'(drop_m));
`else
    check_eq("echo_count_tied", echo_count, 32'd0);
    check_eq("drop_count_tied", drop_count, 32'd0);
`endif
  endtask

  task automatic finish_datagram();
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_eq("idle_timeout", busy, 1'b0);
    @(negedge clk);
    if (expect_echo) echo_m++;
    else drop_m++;
    check_eq("hdr_count", got_hdr.size(), expect_echo ? 1 : 0);
    if (expect_echo && got_hdr.size() > 0) begin
      check_eq("hdr_ttl_dscp_ecn", {got_hdr[0].ttl, got_hdr[0].dscp, got_hdr[0].ecn},
               {exp_hdr.ttl, exp_hdr.dscp, exp_hdr.ecn});
      check_eq("hdr_src_ip", got_hdr[0].sip, exp_hdr.sip);
      check_eq("hdr_dst_ip", got_hdr[0].dip, exp_hdr.dip);
      check_eq("hdr_ports", {got_hdr[0].sp, got_hdr[0].dp}, {exp_hdr.sp, exp_hdr.dp});
      check_eq("hdr_length", got_hdr[0].len, exp_hdr.len);
      check_eq("hdr_checksum", got_hdr[0].csum, 16'd0);
    end
    check_eq("pay_count", got_pay.size(), expect_echo ? exp_n : 0);
    if (expect_echo) begin
      for (int i = 0; i < got_pay.size() && i < exp_n; i++)
        check_eq($sformatf("pay_byte_%0d", i), got_pay[i], {1'b0, i == exp_n - 1, pay_q[i]});
    end
    check_counters();
  endtask

  initial begin
    reset = 1'b1;
    udp_rx_hdr_valid = 0; udp_rx_ip_source_ip = 0; udp_rx_ip_dest_ip = 0;
    udp_rx_source_port = 0; udp_rx_dest_port = 0; udp_rx_length = 0;
    udp_rx_payload_tdata = 0; udp_rx_payload_tvalid = 0; udp_rx_payload_tlast = 0; udp_rx_payload_tuser = 0;
    tx_mode = 0; hdr_delay = 0; rx_gaps = 0; echo_m = 0; drop_m = 0; expect_echo = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_rx_ready", {udp_rx_hdr_ready, udp_rx_payload_tready}, 2'b10);
    check_eq("reset_tx_outputs", {udp_tx_hdr_valid, udp_tx_payload_tvalid, udp_tx_payload_tlast,
                                  udp_tx_payload_tuser, busy}, 5'b0);
    check_counters();
    reset = 1'b0;

    // Known-answer echo, wrong port, bad frame, and length boundaries
    send_datagram(32'h0A000002, 32'h0A000001, 16'd5000, PORT, 12, 4, 0, 1); finish_datagram();
    send_datagram(32'h0A000002, 32'h0A000001, 16'd5000, 16'd9, 18, 10, 0, 0); finish_datagram();
    send_datagram(32'h0A000003, 32'h0A000001, 16'd6000, PORT, 18, 10, 0, 0); finish_datagram();
    send_datagram(32'h0A000004, 32'h0A000001, 16'd6001, PORT, 14, 6, 1, 0); finish_datagram();
    send_datagram(32'h0A000005, 32'h0A000001, 16'd6002, PORT, MP + 9, MP + 1, 0, 0); finish_datagram();
    send_datagram(32'h0A000005, 32'h0A000001, 16'd6002, PORT, MP + 8, MP + 1, 0, 0); finish_datagram();
    send_datagram(32'h0A000006, 32'h0A000001, 16'd6003, PORT, MP + 8, MP, 0, 0); finish_datagram();
    send_datagram(32'h0A000007, 32'h0A000001, 16'd6004, PORT, 8, 1, 0, 0); finish_datagram();
    send_datagram(32'h0A000007, 32'h0A000001, 16'd6004, PORT, 9, 1, 0, 0); finish_datagram();

    // Stalled transmit: random tready plus 3-cycle header ready delay
    tx_mode = 1; hdr_delay = 3; rx_gaps = 1;
    send_datagram(32'hC0A80102, 32'hC0A80101, 16'd1234, PORT, 108, 100, 0, 0); finish_datagram();

    // Reset in the middle of the reply
    tx_mode = 0; hdr_delay = 0;
    send_datagram(32'hC0A80103, 32'hC0A80101, 16'd4321, PORT, 108, 100, 0, 0);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (got_pay.size() >= 50) break;
    end
    check_eq("reply_reached_byte_50", got_pay.size() >= 50, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("midreset_rx_ready", {udp_rx_hdr_ready, udp_rx_payload_tready}, 2'b10);
    check_eq("midreset_tx_outputs", {udp_tx_hdr_valid, udp_tx_payload_tvalid, udp_tx_payload_tlast,
                                     udp_tx_payload_tuser, busy}, 5'b0);
    echo_m = 0; drop_m = 0;
    check_counters();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    got_hdr.delete();
    got_pay.delete();
    send_datagram(32'hC0A80104, 32'hC0A80101, 16'd4000, PORT, 58, 50, 0, 0); finish_datagram();

    // Randomized mix
    for (int unsigned i = 0; i < 14; i++) begin
      logic [15:0] dp;
      int unsigned n, hlen;
      bit bad;
      tx_mode   = $urandom_range(0, 1);
      hdr_delay = $urandom_range(0, 3);
      dp   = ($urandom_range(0, 3) == 0) ? 16'd9 : PORT;
      n    = $urandom_range(1, MP + 2);
      hlen = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MP + 12) : n + 8;
      bad  = ($urandom_range(0, 5) == 0);
      send_datagram($urandom, $urandom, 16'($urandom), dp, hlen, n, bad, 0);
      finish_datagram();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
